// File: rtl/fsm_4_requester.sv
// Initiator for the fsm_4 compute engine: accepts operand pairs, issues them, samples
// the engine result a fixed latency later and checks it against a local reference.
module fsm_4_requester #(
  parameter int LATENCY = 11,
  parameter int GAP     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        valid_data,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [35:0] result,
  output logic        res_valid,
  output logic [35:0] res_data,
  output logic        mismatch,
  output logic [15:0] err_count,
  output logic        busy
);

  // state     | meaning
  // S_IDLE    | ready for an operand pair
  // S_ISSUE   | valid_data high, wait counter loaded
  // S_WAIT    | counting down to the result sample point
  // S_CAPTURE | sample result, compare, update error count
  // S_GAP     | let the engine return to idle before the next issue

  localparam int MAXCNT = (LATENCY > GAP) ? LATENCY : GAP;
  localparam int CW     = $clog2(MAXCNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_GAP
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [35:0] r_exp;
  logic        r_valid_data;
  logic        r_res_valid;
  logic [35:0] r_res_data;
  logic        r_mismatch;
  logic [15:0] r_err_count;

  logic [32:0] w_sum;
  logic [35:0] w_t1;
  logic [35:0] w_t2;
  logic [35:0] w_exp;
  logic        w_mm;

  // Reference kept at full width: 33-bit sum, 36-bit scaled sum.
  assign w_sum = {1'b0, op_a} + {1'b0, op_b};
  assign w_t1  = {1'b0, w_sum, 2'b00} + {4'b0000, op_b};
  assign w_t2  = {5'b00000, op_b[31:1]} + {2'b00, op_a, 2'b00};
  assign w_exp = (w_t1 >> 1) + w_t2;

  assign w_mm  = (result != r_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_exp        <= '0;
      r_valid_data <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_mismatch   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_valid_data <= 1'b0;
      r_res_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_a          <= op_a;
            r_b          <= op_b;
            r_exp        <= w_exp;
            r_valid_data <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= CW'(LATENCY - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == CW'(1)) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_CAPTURE: begin
          r_res_data  <= result;
          r_mismatch  <= w_mm;
          r_res_valid <= 1'b1;
          if (w_mm && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
          end
          r_cnt   <= CW'(GAP);
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign valid_data = r_valid_data;
  assign A          = r_a;
  assign B          = r_b;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign mismatch   = r_mismatch;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_fsm_4_requester.sv
// Directed bench for fsm_4_requester with a simple fixed-latency engine model.
module tb_fsm_4_requester;

  localparam int LAT = 11;
  localparam int GP  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        valid_data;
  logic [31:0] A;
  logic [31:0] B;
  logic [35:0] result;
  logic        res_valid;
  logic [35:0] res_data;
  logic        mismatch;
  logic [15:0] err_count;
  logic        busy;

  fsm_4_requester #(.LATENCY(LAT), .GAP(GP)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .valid_data (valid_data),
    .A          (A),
    .B          (B),
    .result     (result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Engine model and monitor, all on the falling edge.
  logic [35:0] resp_q[$];
  logic [35:0] cur_resp = '0;
  int          issue_at = -1000;
  int          iss_cyc[$];
  logic [31:0] iss_a[$];
  logic [31:0] iss_b[$];
  int          res_cyc[$];
  logic [35:0] res_d[$];
  logic        res_m[$];
  logic [15:0] res_c[$];
  logic [31:0] ia, ib;
  logic        tracking = 1'b0;
  logic        prev_vd = 1'b0;
  int          stab_err = 0;
  int          rdy_err = 0;
  int          vd_err = 0;

  always @(negedge clk) begin
    if (valid_data) begin
      issue_at = cyc;
      cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 36'h0;
      iss_cyc.push_back(cyc);
      iss_a.push_back(A);
      iss_b.push_back(B);
      ia = A;
      ib = B;
      tracking = 1'b1;
    end
    result = (cyc == issue_at + LAT) ? cur_resp : 36'hBADBADBAD;
    if (valid_data && prev_vd) vd_err++;
    prev_vd = valid_data;
    if (op_ready == busy) rdy_err++;
    if (reset) tracking = 1'b0;
    else if (tracking && ((A !== ia) || (B !== ib))) stab_err++;
    if (res_valid) begin
      res_cyc.push_back(cyc);
      res_d.push_back(res_data);
      res_m.push_back(mismatch);
      res_c.push_back(err_count);
      tracking = 1'b0;
    end
  end

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [35:0] r);
    int k = 0;
    resp_q.push_back(r);
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    while (!op_ready && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (!op_ready) chk("offer_timeout", 64'(op_ready), 64'd1);
    @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic wait_res(input int n, input string tag);
    int k = 0;
    while (res_cyc.size() < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (res_cyc.size() < n) chk({tag, "_timeout"}, 64'(res_cyc.size()), 64'(n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base;

  initial begin
    reset = 1'b1;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    idle(3);
    chk("rst_valid_data", 64'(valid_data), 64'd0);
    chk("rst_A",          64'(A),          64'd0);
    chk("rst_B",          64'(B),          64'd0);
    chk("rst_res_valid",  64'(res_valid),  64'd0);
    chk("rst_res_data",   64'(res_data),   64'd0);
    chk("rst_mismatch",   64'(mismatch),   64'd0);
    chk("rst_err_count",  64'(err_count),  64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_op_ready",   64'(op_ready),   64'd1);
    reset = 1'b0;
    idle(2);

    // 1: matching result
    offer(32'd3, 32'd8, 36'd42);
    op_valid = 1'b0;
    wait_res(1, "t1");
    if (res_cyc.size() >= 1) begin
      chk("t1_issue_A",  64'(iss_a[0]), 64'd3);
      chk("t1_issue_B",  64'(iss_b[0]), 64'd8);
      chk("t1_latency",  64'(res_cyc[0] - iss_cyc[0]), 64'(LAT + 1));
      chk("t1_res_data", 64'(res_d[0]), 64'd42);
      chk("t1_mismatch", 64'(res_m[0]), 64'd0);
      chk("t1_err",      64'(res_c[0]), 64'd0);
    end
    idle(1);
    chk("t1_res_valid_pulse", 64'(res_valid), 64'd0);

    // 2: mismatching result, outputs hold afterwards
    offer(32'd32, 32'd128, 36'd577);
    op_valid = 1'b0;
    wait_res(2, "t2");
    if (res_cyc.size() >= 2) begin
      chk("t2_res_data", 64'(res_d[1]), 64'd577);
      chk("t2_mismatch", 64'(res_m[1]), 64'd1);
      chk("t2_err",      64'(res_c[1]), 64'd1);
    end
    idle(6);
    chk("t2_hold_data", 64'(res_data),  64'd577);
    chk("t2_hold_mm",   64'(mismatch),  64'd1);
    chk("t2_hold_err",  64'(err_count), 64'd1);

    // 3: full-width operands
    offer(32'hFFFFFFFF, 32'hFFFFFFFF, 36'h8FFFFFFF6);
    op_valid = 1'b0;
    wait_res(3, "t3");
    if (res_cyc.size() >= 3) begin
      chk("t3_res_data", 64'(res_d[2]), 64'h8FFFFFFF6);
      chk("t3_mismatch", 64'(res_m[2]), 64'd0);
      chk("t3_err",      64'(res_c[2]), 64'd1);
    end
    idle(2);

    // 4: op_valid held high across three pairs
    offer(32'd1,   32'd2,   36'd12);
    offer(32'd5,   32'd7,   36'd50);
    offer(32'd100, 32'd200, 36'd1200);
    op_valid = 1'b0;
    wait_res(6, "t4");
    if (res_cyc.size() >= 6 && iss_cyc.size() >= 6) begin
      chk("t4_spacing_1", 64'(iss_cyc[4] - iss_cyc[3]), 64'(LAT + GP + 2));
      chk("t4_spacing_2", 64'(iss_cyc[5] - iss_cyc[4]), 64'(LAT + GP + 2));
      chk("t4_issue_A2",  64'(iss_a[4]), 64'd5);
      chk("t4_issue_B3",  64'(iss_b[5]), 64'd200);
      chk("t4_data_1",    64'(res_d[3]), 64'd12);
      chk("t4_data_2",    64'(res_d[4]), 64'd50);
      chk("t4_data_3",    64'(res_d[5]), 64'd1200);
      chk("t4_mm_any",    64'({res_m[3], res_m[4], res_m[5]}), 64'd0);
    end
    chk("t4_ab_stable",     64'(stab_err), 64'd0);
    chk("t4_ready_only_idle", 64'(rdy_err), 64'd0);
    chk("t4_valid_one_cycle", 64'(vd_err), 64'd0);
    idle(2);

    // 5: reset during WAIT aborts the transaction
    offer(32'd9, 32'd9, 36'd0);
    op_valid = 1'b0;
    idle(4);
    chk("t5_in_wait_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    idle(1);
    chk("t5_busy",       64'(busy),       64'd0);
    chk("t5_op_ready",   64'(op_ready),   64'd1);
    chk("t5_valid_data", 64'(valid_data), 64'd0);
    chk("t5_res_valid",  64'(res_valid),  64'd0);
    chk("t5_err",        64'(err_count),  64'd0);
    chk("t5_A",          64'(A),          64'd0);
    reset = 1'b0;
    idle(LAT + GP + 4);
    chk("t5_no_capture", 64'(res_cyc.size()), 64'd6);
    chk("t5_err_after",  64'(err_count),  64'd0);

    // 6: error count saturation
    force dut.r_err_count = 16'hFFFE;
    idle(1);
    release dut.r_err_count;
    idle(1);
    base = res_cyc.size();
    offer(32'd1, 32'd1, 36'd0);
    op_valid = 1'b0;
    wait_res(base + 1, "t6a");
    if (res_cyc.size() >= base + 1) begin
      chk("t6_err_reach_max", 64'(res_c[base]), 64'hFFFF);
      chk("t6_mm_a",          64'(res_m[base]), 64'd1);
    end
    idle(2);
    offer(32'd1, 32'd1, 36'd7);
    op_valid = 1'b0;
    wait_res(base + 2, "t6b");
    if (res_cyc.size() >= base + 2) begin
      chk("t6_err_saturated", 64'(res_c[base + 1]), 64'hFFFF);
      chk("t6_mm_b",          64'(res_m[base + 1]), 64'd1);
      chk("t6_data_b",        64'(res_d[base + 1]), 64'd7);
    end
    idle(2);
    offer(32'd1, 32'd1, 36'd8);
    op_valid = 1'b0;
    wait_res(base + 3, "t6c");
    if (res_cyc.size() >= base + 3) begin
      chk("t6_err_held", 64'(res_c[base + 2]), 64'hFFFF);
      chk("t6_mm_c",     64'(res_m[base + 2]), 64'd0);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
